pic_inta_ctrl: RTL

Interrupt-acknowledge sequencer for the 8259A-style PIC, 8086 mode. It sits between the priority resolver and the cascade comparator. It raises INT, tracks the two INTA pulses, latches the winning IR level, sets ISR and clears IRR, and drives the slave ID on CAS when it is the master. On pulse 2 it puts the vector on the data bus, gated by the comparator's match signal when it is a slave.

---
 rtl/pic_pkg.sv | 24 ++
 rtl/pic_inta_ctrl_if.sv | 38 +++
 rtl/pic_sync_edge.sv | 35 +++
 rtl/pic_inta_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style interrupt-acknowledge sequencer.
package pic_pkg;

  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned VEC_W   = 8;
  localparam int unsigned BASE_W  = VEC_W - LEVEL_W;

  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_GAP,
    ST_ACK2
  } state_e;

  // Vector byte is a plain concatenation, never an add.
  function automatic logic [VEC_W-1:0] make_vector(input logic [BASE_W-1:0]  base,
                                                   input logic [LEVEL_W-1:0] lvl);
    return {base, lvl};
  endfunction

endpackage

// File: rtl/pic_inta_ctrl_if.sv
// CPU/resolver/cascade-side signals of the INTA sequencer.
interface pic_inta_ctrl_if;
  import pic_pkg::*;

  logic                 inta_n;
  logic                 int_req;
  logic [LEVEL_W-1:0]   irq_level;
  logic [BASE_W-1:0]    vector_base;
  logic                 sngl;
  logic                 sp_en_n;
  logic [7:0]           slave_map;
  logic                 aeoi;
  logic                 cas_match;

  logic                 int_out;
  logic                 isr_set;
  logic                 irr_clr;
  logic [LEVEL_W-1:0]   isr_level;
  logic                 auto_eoi;
  logic [LEVEL_W-1:0]   cas_out;
  logic                 cas_oe;
  logic [VEC_W-1:0]     data_out;
  logic                 data_oe;
  logic                 spurious;

  modport master (
    input  inta_n, int_req, irq_level, vector_base, sngl, sp_en_n, slave_map, aeoi, cas_match,
    output int_out, isr_set, irr_clr, isr_level, auto_eoi, cas_out, cas_oe, data_out, data_oe,
           spurious
  );

  modport slave (
    output inta_n, int_req, irq_level, vector_base, sngl, sp_en_n, slave_map, aeoi, cas_match,
    input  int_out, isr_set, irr_clr, isr_level, auto_eoi, cas_out, cas_oe, data_out, data_oe,
           spurious
  );

endinterface

// File: rtl/pic_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses; STAGES must be at least 2.
module pic_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= ~prev_q & sync_q[STAGES-1];
      fall_q <= prev_q & ~sync_q[STAGES-1];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pic_inta_ctrl.sv
// 8086-mode INTA sequencer: raises INT, tracks both INTA pulses, drives CAS and the vector.
module pic_inta_ctrl
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pic_inta_ctrl_if.master  bus
);

  logic inta_rise, inta_fall;

  pic_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_inta_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.inta_n),
    .rise_o  (inta_rise),
    .fall_o  (inta_fall)
  );

  state_e               state_q, state_d;
  logic                 int_out_q, int_out_d;
  logic                 isr_set_q, isr_set_d;
  logic                 irr_clr_q, irr_clr_d;
  logic                 auto_eoi_q, auto_eoi_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 spurious_q, spurious_d;
  logic                 cas_oe_q, cas_oe_d;
  logic [LEVEL_W-1:0]   cas_out_q, cas_out_d;
  logic                 data_oe_q, data_oe_d;
  logic [VEC_W-1:0]     data_out_q, data_out_d;

  logic                 master_c;
  logic [LEVEL_W-1:0]   ack_level_c;
  logic                 cas_sel_c;
  logic                 data_sel_c;

  assign master_c    = bus.sp_en_n & ~bus.sngl;
  assign ack_level_c = bus.int_req ? bus.irq_level : SPURIOUS_LEVEL;
  assign cas_sel_c   = master_c & bus.slave_map[ack_level_c];
  // A slave re-samples cas_match every cycle of pulse 2.
  assign data_sel_c  = bus.sngl
                     | (master_c & ~bus.slave_map[level_q])
                     | (~bus.sp_en_n & ~bus.sngl & bus.cas_match);

  always_comb begin
    state_d    = state_q;
    int_out_d  = 1'b0;
    isr_set_d  = 1'b0;
    irr_clr_d  = 1'b0;
    auto_eoi_d = 1'b0;
    level_d    = level_q;
    spurious_d = spurious_q;
    cas_oe_d   = cas_oe_q;
    cas_out_d  = cas_out_q;
    data_oe_d  = 1'b0;
    data_out_d = data_out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.int_req) begin
          state_d   = ST_REQ;
          int_out_d = 1'b1;
        end
      end
      // INT stays up even if the request vanishes; the CPU is already committed.
      ST_REQ: begin
        int_out_d = 1'b1;
        if (inta_fall) begin
          state_d    = ST_ACK1;
          int_out_d  = 1'b0;
          level_d    = ack_level_c;
          spurious_d = ~bus.int_req;
          isr_set_d  = bus.int_req;
          irr_clr_d  = bus.int_req;
          cas_oe_d   = cas_sel_c;
          cas_out_d  = cas_sel_c ? ack_level_c : LEVEL_W'(0);
        end
      end
      ST_ACK1: begin
        if (inta_rise) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (inta_fall) begin
          state_d    = ST_ACK2;
          data_oe_d  = data_sel_c;
          data_out_d = make_vector(bus.vector_base, level_q);
        end
      end
      ST_ACK2: begin
        data_oe_d = data_sel_c;
        if (inta_rise) begin
          state_d    = ST_IDLE;
          data_oe_d  = 1'b0;
          data_out_d = VEC_W'(0);
          cas_oe_d   = 1'b0;
          cas_out_d  = LEVEL_W'(0);
          auto_eoi_d = bus.aeoi & ~spurious_q;
          spurious_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      int_out_q  <= 1'b0;
      isr_set_q  <= 1'b0;
      irr_clr_q  <= 1'b0;
      auto_eoi_q <= 1'b0;
      level_q    <= LEVEL_W'(0);
      spurious_q <= 1'b0;
      cas_oe_q   <= 1'b0;
      cas_out_q  <= LEVEL_W'(0);
      data_oe_q  <= 1'b0;
      data_out_q <= VEC_W'(0);
    end else begin
      state_q    <= state_d;
      int_out_q  <= int_out_d;
      isr_set_q  <= isr_set_d;
      irr_clr_q  <= irr_clr_d;
      auto_eoi_q <= auto_eoi_d;
      level_q    <= level_d;
      spurious_q <= spurious_d;
      cas_oe_q   <= cas_oe_d;
      cas_out_q  <= cas_out_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.int_out   = int_out_q;
  assign bus.isr_set   = isr_set_q;
  assign bus.irr_clr   = irr_clr_q;
  assign bus.isr_level = level_q;
  assign bus.auto_eoi  = auto_eoi_q;
  assign bus.spurious  = spurious_q;
  assign bus.cas_oe    = cas_oe_q;
  assign bus.cas_out   = cas_out_q;
  assign bus.data_oe   = data_oe_q;
  assign bus.data_out  = data_out_q;

endmodule
